// File: rtl/stream_min_max_pkg.sv
// Shared definitions for the streaming min/max reduction block.
package stream_min_max_pkg;

  localparam int unsigned DEFAULT_INPUT_BIT_WIDTH = 8;
  localparam int unsigned DEFAULT_COUNT_WIDTH     = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/stream_min_max_step.sv
// One reduction step: folds a new sample into the running min/max.
module min_max_step
  import stream_min_max_pkg::*;
#(
  parameter int unsigned W = DEFAULT_INPUT_BIT_WIDTH
) (
  input  logic [W-1:0] i_min,
  input  logic [W-1:0] i_max,
  input  logic [W-1:0] i_sample,
  input  logic         i_first,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_max
);

  // First sample seeds both bounds; later samples replace a bound only on a strict win.
  always_comb begin
    o_min = i_min;
    o_max = i_max;
    if (i_first) begin
      o_min = i_sample;
      o_max = i_sample;
    end else begin
      if (i_sample < i_min) o_min = i_sample;
      if (i_sample > i_max) o_max = i_sample;
    end
  end

endmodule

// File: rtl/stream_min_max.sv
// Streaming min/max/count reduction over valid/ready framed input,
// one registered result word per frame.
module stream_min_max
  import stream_min_max_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = DEFAULT_INPUT_BIT_WIDTH,
  parameter int unsigned COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [INPUT_BIT_WIDTH-1:0] InData,
  input  logic                       InLast,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [INPUT_BIT_WIDTH-1:0] Min,
  output logic [INPUT_BIT_WIDTH-1:0] Max,
  output logic [COUNT_WIDTH-1:0]     Count
);

  state_t                     r_state;
  logic                       r_first;
  logic [INPUT_BIT_WIDTH-1:0] r_min;
  logic [INPUT_BIT_WIDTH-1:0] r_max;
  logic [COUNT_WIDTH-1:0]     r_count;

  state_t                     w_state_nxt;
  logic                       w_first_nxt;
  logic [INPUT_BIT_WIDTH-1:0] w_min_nxt;
  logic [INPUT_BIT_WIDTH-1:0] w_max_nxt;
  logic [COUNT_WIDTH-1:0]     w_count_nxt;
  logic [INPUT_BIT_WIDTH-1:0] w_step_min;
  logic [INPUT_BIT_WIDTH-1:0] w_step_max;

  min_max_step #(
    .W (INPUT_BIT_WIDTH)
  ) u_step (
    .i_min    (r_min),
    .i_max    (r_max),
    .i_sample (InData),
    .i_first  (r_first),
    .o_min    (w_step_min),
    .o_max    (w_step_max)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ACCUM;
      r_first <= 1'b1;
      r_min   <= '0;
      r_max   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_first_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state, accumulation and handshake outputs; both ready/valid derive from state only.
  always_comb begin
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    w_min_nxt   = r_min;
    w_max_nxt   = r_max;
    w_count_nxt = r_count;
    InReady     = 1'b0;
    OutValid    = 1'b0;
    unique case (r_state)
      ACCUM: begin
        InReady = 1'b1;
        if (InValid) begin
          w_min_nxt   = w_step_min;
          w_max_nxt   = w_step_max;
          w_first_nxt = 1'b0;
          if (r_first) begin
            w_count_nxt = COUNT_WIDTH'(1);
          end else if (r_count != '1) begin
            w_count_nxt = r_count + COUNT_WIDTH'(1);
          end
          if (InLast) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        OutValid = 1'b1;
        if (OutReady) begin
          w_state_nxt = ACCUM;
          w_first_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  assign Min   = r_min;
  assign Max   = r_max;
  assign Count = r_count;

endmodule
